// File: rtl/vu_level_meter.sv
// vu_level_meter: turns received signed sample bytes into an LED bar level with
// fast attack and linear decay, plus an optional peak-hold dot.
// Optional feature macro: VU_PEAK_HOLD_EN builds the peak register, hold counter
// and peak FSM; without it peak_dot is tied to all zeros.
module vu_level_meter #(
    parameter int NUM_LEDS    = 8,
    parameter int DECAY_TICKS = 600,
    parameter int HOLD_TICKS  = 9600
) (
    input  logic                clkx16,
    input  logic                reset,
    input  logic [7:0]          data,
    input  logic                load,
    input  logic                error,
    output logic [NUM_LEDS-1:0] bar,
    output logic [NUM_LEDS-1:0] peak_dot,
    output logic                fault
);

    localparam int CW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DECAY_TICKS - 1);

    logic [CW-1:0] count;
    logic          tick;
    logic [6:0]    level;
    logic [6:0]    level_next;
    logic [6:0]    mag;
    logic [6:0]    dec;
    logic [7:0]    data_neg;

    assign tick     = (count == TICK_LAST);
    assign data_neg = 8'd0 - data;

    // Magnitude of the signed sample, with -128 saturating to 127, and the next level
    always_comb begin
        mag = data[6:0];
        if (data[7]) begin
            mag = (data == 8'h80) ? 7'd127 : data_neg[6:0];
        end
        dec = (tick && level != 7'd0) ? level - 7'd1 : level;
        level_next = dec;
        if (error) begin
            level_next = 7'd0;
        end else if (load && mag > dec) begin
            level_next = mag;
        end
    end

    // Free-running decay tick counter, level register and registered fault flag
    always_ff @(posedge clkx16) begin
        if (reset) begin
            count <= '0;
            level <= 7'd0;
            fault <= 1'b0;
        end else begin
            count <= tick ? '0 : count + CW'(1);
            level <= level_next;
            fault <= error;
        end
    end

    // Thermometer decode: LED i lights when level exceeds i*128/NUM_LEDS
    always_comb begin
        bar = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            bar[i] = (level > 7'((i * 128) / NUM_LEDS));
        end
    end

`ifdef VU_PEAK_HOLD_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {P_IDLE, P_HOLD, P_FALL} peak_state_t;

    peak_state_t   state;
    logic [6:0]    peak;
    logic [6:0]    peak_fall;
    logic [HW-1:0] hold;

    // Falling peak value for this cycle, never allowed to drop below the new level
    always_comb begin
        peak_fall = (tick && peak != 7'd0) ? peak - 7'd1 : peak;
        if (peak_fall < level_next) begin
            peak_fall = level_next;
        end
    end

    // Peak FSM: capture on a new maximum, hold for HOLD_TICKS, then fall with the decay tick
    always_ff @(posedge clkx16) begin
        if (reset) begin
            state <= P_IDLE;
            peak  <= 7'd0;
            hold  <= '0;
        end else if (error) begin
            state <= P_IDLE;
            peak  <= 7'd0;
            hold  <= '0;
        end else if (level_next > peak) begin
            state <= P_HOLD;
            peak  <= level_next;
            hold  <= HOLD_LOAD;
        end else begin
            case (state)
                P_HOLD: begin
                    if (hold == '0) begin
                        state <= P_FALL;
                    end else begin
                        hold <= hold - HW'(1);
                    end
                end
                P_FALL: begin
                    peak <= peak_fall;
                    if (peak_fall == 7'd0) begin
                        state <= P_IDLE;
                    end
                end
                default: state <= P_IDLE;
            endcase
        end
    end

    // One-hot dot at the highest LED whose threshold the peak exceeds
    always_comb begin
        peak_dot = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (peak > 7'((i * 128) / NUM_LEDS)) begin
                peak_dot    = '0;
                peak_dot[i] = 1'b1;
            end
        end
    end
`else
    assign peak_dot = '0;
`endif

endmodule

// File: tb/tb_vu_level_meter.sv
// tb_vu_level_meter: table vectors, hand-written decay/collision/restart sequences
// and a randomized run against an arithmetic reference model of the level meter.
module tb_vu_level_meter;

    localparam int NUM_LEDS    = 8;
    localparam int DECAY_TICKS = 4;
    localparam int HOLD_TICKS  = 8;

    logic                clkx16 = 1'b0;
    logic                reset  = 1'b1;
    logic [7:0]          data   = 8'h00;
    logic                load   = 1'b0;
    logic                error  = 1'b0;
    logic [NUM_LEDS-1:0] bar;
    logic [NUM_LEDS-1:0] peak_dot;
    logic                fault;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_level = 0;
    int m_peak  = 0;
    int m_age   = 0;
    int m_n     = 0;
    int m_fault = 0;

    vu_level_meter #(
        .NUM_LEDS   (NUM_LEDS),
        .DECAY_TICKS(DECAY_TICKS),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clkx16  (clkx16),
        .reset   (reset),
        .data    (data),
        .load    (load),
        .error   (error),
        .bar     (bar),
        .peak_dot(peak_dot),
        .fault   (fault)
    );

    always #5 clkx16 = ~clkx16;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] d;
        logic       err;
        logic [7:0] exp_bar;
        logic [7:0] exp_dot;
        logic       exp_fault;
    } vec_t;

    vec_t vecs[14];

    function automatic int sample_mag(input logic [7:0] d);
        int v;
        v = d[7] ? int'(d) - 256 : int'(d);
        if (v < 0) v = -v;
        if (v > 127) v = 127;
        return v;
    endfunction

    // Number of lit LEDs is ceil(level / 16) for 8 LEDs over 0..127
    function automatic logic [7:0] model_bar(input int lvl);
        int n;
        n = (lvl + (128 / NUM_LEDS) - 1) / (128 / NUM_LEDS);
        return 8'((1 << n) - 1);
    endfunction

    function automatic logic [7:0] model_dot(input int pk);
`ifdef VU_PEAK_HOLD_EN
        if (pk == 0) return 8'h00;
        return 8'(1 << ((pk - 1) / (128 / NUM_LEDS)));
`else
        return (pk < 0) ? 8'hFF : 8'h00;
`endif
    endfunction

    // One clock edge of the behavioural model, fed with the inputs that edge samples
    task automatic model_step(input logic rst, input logic ld, input logic [7:0] d, input logic err);
        int tick;
        int nl;
        if (rst) begin
            m_level = 0; m_peak = 0; m_age = 0; m_n = 0; m_fault = 0;
        end else begin
            tick = ((m_n % DECAY_TICKS) == DECAY_TICKS - 1) ? 1 : 0;
            m_n++;
            m_fault = err ? 1 : 0;
            if (err) begin
                m_level = 0; m_peak = 0; m_age = 0;
            end else begin
                nl = (tick == 1 && m_level > 0) ? m_level - 1 : m_level;
                if (ld && sample_mag(d) > nl) nl = sample_mag(d);
                if (nl > m_peak) begin
                    m_peak = nl;
                    m_age  = 0;
                end else if (m_peak > 0) begin
                    if (m_age >= HOLD_TICKS && tick == 1) begin
                        m_peak = (m_peak - 1 > nl) ? m_peak - 1 : nl;
                    end
                    if (m_age < 1000) m_age++;
                end
                m_level = nl;
            end
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic ld, input logic [7:0] d, input logic err);
        @(negedge clkx16);
        reset = rst;
        load  = ld;
        data  = d;
        error = err;
        model_step(rst, ld, d, err);
        @(posedge clkx16);
        #1;
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // Table vectors, one clock edge per row, starting from reset
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h0F, 8'h08, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h0F, 8'h08, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h80, 1'b0, 8'hFF, 8'h80, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 8'h80, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'h7F, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h01, 8'h01, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h50, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h7F, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'h20, 1'b0, 8'h03, 8'h02, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'hE0, 1'b0, 8'h03, 8'h02, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'h81, 1'b0, 8'hFF, 8'h80, 1'b0};

        for (int i = 0; i < 14; i++) begin
            logic [7:0] edot;
            apply_stimulus(vecs[i].rst, vecs[i].ld, vecs[i].d, vecs[i].err);
`ifdef VU_PEAK_HOLD_EN
            edot = vecs[i].exp_dot;
`else
            edot = 8'h00;
`endif
            check_output($sformatf("vec%0d_bar", i), 16'(bar), 16'(vecs[i].exp_bar));
            check_output($sformatf("vec%0d_dot", i), 16'(peak_dot), 16'(edot));
            check_output($sformatf("vec%0d_fault", i), 16'(fault), 16'(vecs[i].exp_fault));
        end

        // Decay: single full-scale load, level drops one step every 4 edges
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'h7F, 1'b0);
        repeat (58) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("decay_level_113", 16'(dut.level), 16'd113);
        check_output("decay_bar_ff", 16'(bar), 16'h00FF);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("decay_level_112", 16'(dut.level), 16'd112);
        check_output("decay_bar_7f", 16'(bar), 16'h007F);
`ifdef VU_PEAK_HOLD_EN
        check_output("decay_peak_114", 16'(dut.peak), 16'd114);
        check_output("decay_dot_80", 16'(peak_dot), 16'h0080);
`endif

        // Attack against decay in a tick cycle
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'h32, 1'b0);
        repeat (2) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'hD0, 1'b0);
        check_output("collide_small_49", 16'(dut.level), 16'd49);
        repeat (3) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'h3C, 1'b0);
        check_output("collide_large_60", 16'(dut.level), 16'd60);

`ifdef VU_PEAK_HOLD_EN
        // Peak restart while falling: new maximum restarts the full hold
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'h5A, 1'b0);
        repeat (11) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("restart_falling_89", 16'(dut.peak), 16'd89);
        apply_stimulus(1'b0, 1'b1, 8'h64, 1'b0);
        check_output("restart_peak_100", 16'(dut.peak), 16'd100);
        check_output("restart_dot_40", 16'(peak_dot), 16'h0040);
        repeat (8) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("restart_held_100", 16'(dut.peak), 16'd100);
        repeat (8) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("restart_fall_98", 16'(dut.peak), 16'd98);
`endif

        // Randomized run against the reference model
        begin
            logic err_lvl;
            logic rst_r;
            logic ld_r;
            logic [7:0] d_r;
            err_lvl = 1'b0;
            apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
            for (int c = 0; c < 3000; c++) begin
                rst_r = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 149) == 0) err_lvl = ~err_lvl;
                ld_r = ($urandom_range(0, 5) == 0);
                case ($urandom_range(0, 9))
                    0: d_r = 8'h80;
                    1: d_r = 8'h00;
                    2: d_r = 8'hFF;
                    default: d_r = 8'($urandom);
                endcase
                apply_stimulus(rst_r, ld_r, d_r, err_lvl);
                check_output("rand_bar", 16'(bar), 16'(model_bar(m_level)));
                check_output("rand_dot", 16'(peak_dot), 16'(model_dot(m_peak)));
                check_output("rand_fault", 16'(fault), 16'(m_fault));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
